// File: rtl/param_compute_unit_if.sv
// param_compute_unit_if: instruction/result bundle between sequencer (master) and compute unit (slave)
// Parameters: DATA_W datapath width, NUM_REGS register count (RAW = $clog2(NUM_REGS)).
// Instruction side: in_valid, in_ready, opcode[3:0], tgt_id, src0_id, src1_id, imm.
// Result side: out_valid, out_data, out_reg_id, out_zero, out_carry, err.
interface param_compute_unit_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16
);
    localparam int RAW = $clog2(NUM_REGS);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        opcode;
    logic [RAW-1:0]    tgt_id;
    logic [RAW-1:0]    src0_id;
    logic [RAW-1:0]    src1_id;
    logic [DATA_W-1:0] imm;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [RAW-1:0]    out_reg_id;
    logic              out_zero;
    logic              out_carry;
    logic              err;
    modport master (
        output in_valid, opcode, tgt_id, src0_id, src1_id, imm,
        input  in_ready, out_valid, out_data, out_reg_id, out_zero, out_carry, err
    );
    modport slave (
        input  in_valid, opcode, tgt_id, src0_id, src1_id, imm,
        output in_ready, out_valid, out_data, out_reg_id, out_zero, out_carry, err
    );
endinterface

// File: rtl/param_compute_unit.sv
// param_compute_unit: register-file ALU, one instruction per handshake, result strobe with zero/carry flags
// Ports: clk, rst (sync, active-high), bus (param_compute_unit_if.slave: instruction in, result/err out).
// Optional multi-cycle shift-add multiply (opcode A) is built only when CU_MUL_EN is defined;
// otherwise opcode A is illegal and in_ready is tied high.
module param_compute_unit #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16
) (
    input logic                  clk,
    input logic                  rst,
    param_compute_unit_if.slave  bus
);
    localparam int RAW = $clog2(NUM_REGS);
    localparam int SW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] a, b;
    logic [DATA_W:0]   res;
    logic              legal;
    logic              accept;

    assign a      = regs[bus.src0_id];
    assign b      = regs[bus.src1_id];
    assign accept = bus.in_valid & bus.in_ready;

    // res[DATA_W] is the carry/borrow; every other op zero-extends so it stays 0
    always_comb begin
        res   = '0;
        legal = 1'b1;
        case (bus.opcode)
            4'h1:    res = {1'b0, bus.imm};
            4'h2:    res = {1'b0, a} + {1'b0, b};
            4'h3:    res = {1'b0, a} - {1'b0, b};
            4'h4:    res = {1'b0, a & b};
            4'h5:    res = {1'b0, a | b};
            4'h6:    res = {1'b0, ~a};
            4'h7:    res = {1'b0, a ^ b};
            4'h8:    res = {1'b0, a << b[SW-1:0]};
            4'h9:    res = {1'b0, a >> b[SW-1:0]};
            default: legal = 1'b0;
        endcase
    end

`ifdef CU_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;
    localparam logic [SW:0] LAST = (SW+1)'(DATA_W - 1);
    state_t              state;
    logic [2*DATA_W-1:0] m_acc, m_a, prod;
    logic [DATA_W-1:0]   m_b;
    logic [SW:0]         cnt;
    logic [RAW-1:0]      m_tgt;
    // one partial product per cycle: multiplicand shifts left, multiplier shifts right
    assign prod         = m_acc + (m_b[0] ? m_a : '0);
    assign bus.in_ready = (state == IDLE);
`else
    assign bus.in_ready = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_reg_id <= '0;
            bus.out_zero   <= 1'b0;
            bus.out_carry  <= 1'b0;
            bus.err        <= 1'b0;
`ifdef CU_MUL_EN
            state <= IDLE;
            m_acc <= '0;
            m_a   <= '0;
            m_b   <= '0;
            cnt   <= '0;
            m_tgt <= '0;
`endif
        end else begin
            bus.out_valid <= 1'b0;
            bus.err       <= 1'b0;
`ifdef CU_MUL_EN
            if (state == MUL) begin
                m_acc <= prod;
                m_a   <= m_a << 1;
                m_b   <= m_b >> 1;
                cnt   <= cnt + 1'b1;
                if (cnt == LAST) begin
                    regs[m_tgt]    <= prod[DATA_W-1:0];
                    bus.out_valid  <= 1'b1;
                    bus.out_data   <= prod[DATA_W-1:0];
                    bus.out_reg_id <= m_tgt;
                    bus.out_zero   <= (prod[DATA_W-1:0] == '0);
                    bus.out_carry  <= |prod[2*DATA_W-1:DATA_W];
                    state          <= IDLE;
                end
            end else if (accept && bus.opcode == 4'hA) begin
                m_acc <= '0;
                m_a   <= {{DATA_W{1'b0}}, a};
                m_b   <= b;
                cnt   <= '0;
                m_tgt <= bus.tgt_id;
                state <= MUL;
            end else
`endif
            if (accept && legal) begin
                regs[bus.tgt_id] <= res[DATA_W-1:0];
                bus.out_valid    <= 1'b1;
                bus.out_data     <= res[DATA_W-1:0];
                bus.out_reg_id   <= bus.tgt_id;
                bus.out_zero     <= (res[DATA_W-1:0] == '0);
                bus.out_carry    <= res[DATA_W];
            end else if (accept && bus.opcode != 4'h0) begin
                bus.err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_param_compute_unit.sv
// tb_param_compute_unit: scoreboard bench, directed plus random instructions against an arithmetic reference model
module tb_param_compute_unit;
    localparam int W   = 8;
    localparam int N   = 16;
    localparam int RAW = 4;
`ifdef CU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0]    cyc;
        logic [RAW-1:0] id;
        logic [W-1:0]   d;
        logic           c;
        logic           e;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    param_compute_unit_if #(.DATA_W(W), .NUM_REGS(N)) bus ();
    param_compute_unit #(.DATA_W(W), .NUM_REGS(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t           q[$];
    logic [W-1:0]   mr [N];
    int             cyc = 0;
    int             mul_cyc = -1000;
    int             vecs = 0;
    int             miss = 0;
    logic [W-1:0]   last_d = '0;
    logic [RAW-1:0] last_id = '0;
    logic           last_z = 1'b0;
    logic           last_c = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // called the cycle before the accepting edge; operands are pre-write register values
    task automatic model(input logic [3:0] op, input int t, input int s0, input int s1, input logic [W-1:0] im);
        longint m = longint'(1) << W;
        longint a = longint'(mr[s0]);
        longint b = longint'(mr[s1]);
        longint r = 0;
        bit ok = 1'b1;
        bit c = 1'b0;
        int lat = 1;
        exp_t e;
        case (op)
            4'h1: r = longint'(im);
            4'h2: begin r = a + b; c = (r >= m); end
            4'h3: begin r = a - b + m; c = (a < b); end
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: r = m - 1 - a;
            4'h7: r = a ^ b;
            4'h8: r = a * (longint'(1) << (b % W));
            4'h9: r = a / (longint'(1) << (b % W));
            4'hA: if (MUL_EN) begin r = a * b; c = (r >= m); lat = W; mul_cyc = cyc + 1; end else ok = 1'b0;
            default: ok = 1'b0;
        endcase
        r = r % m;
        e.cyc = 32'(cyc + lat);
        e.id  = RAW'(t);
        e.d   = W'(r);
        e.c   = c;
        e.e   = 1'b0;
        if (ok) begin
            mr[t] = W'(r);
            q.push_back(e);
        end else if (op != 4'h0) begin
            e.cyc = 32'(cyc + 1);
            e.e   = 1'b1;
            q.push_back(e);
        end
    endtask

    // while the unit is busy, in_valid stays high with junk fields that must be ignored
    task automatic issue(input logic [3:0] op, input int t, input int s0, input int s1, input logic [W-1:0] im);
        int n = 0;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            bus.opcode  = 4'($urandom);
            bus.tgt_id  = RAW'($urandom);
            bus.src0_id = RAW'($urandom);
            bus.src1_id = RAW'($urandom);
            bus.imm     = W'($urandom);
            @(negedge clk);
            n++;
        end
        bus.opcode  = op;
        bus.tgt_id  = RAW'(t);
        bus.src0_id = RAW'(s0);
        bus.src1_id = RAW'(s1);
        bus.imm     = im;
        if (!bus.in_ready) begin
            vecs++;
            miss++;
            $display("FAIL issue_timeout in_ready=%b required 1", bus.in_ready);
        end else begin
            model(op, t, s0, s1, im);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        q.delete();
        for (int i = 0; i < N; i++) mr[i] = '0;
        last_d  = '0;
        last_id = '0;
        last_z  = 1'b0;
        last_c  = 1'b0;
        mul_cyc = -1000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        logic exp_v, exp_e, exp_r;
        forever begin
            @(posedge clk);
            #2;
            exp_v = 1'b0;
            exp_e = 1'b0;
            while (q.size() > 0 && int'(q[0].cyc) < cyc) begin
                e = q.pop_front();
                vecs++;
                miss++;
                $display("FAIL missing_output id=%0d due cycle %0d, absent at cycle %0d", e.id, e.cyc, cyc);
            end
            if (q.size() > 0 && int'(q[0].cyc) == cyc) begin
                e = q.pop_front();
                if (e.e) exp_e = 1'b1;
                else begin
                    exp_v   = 1'b1;
                    last_d  = e.d;
                    last_id = e.id;
                    last_z  = (e.d == '0);
                    last_c  = e.c;
                end
            end
            vecs++;
            if ({bus.out_valid, bus.err, bus.out_data, bus.out_reg_id, bus.out_zero, bus.out_carry} !==
                {exp_v, exp_e, last_d, last_id, last_z, last_c}) begin
                miss++;
                $display("FAIL outputs cycle %0d got v=%b err=%b d=%h id=%0d z=%b c=%b required v=%b err=%b d=%h id=%0d z=%b c=%b",
                         cyc, bus.out_valid, bus.err, bus.out_data, bus.out_reg_id, bus.out_zero, bus.out_carry,
                         exp_v, exp_e, last_d, last_id, last_z, last_c);
            end
            exp_r = !(cyc >= mul_cyc && cyc < mul_cyc + W);
            vecs++;
            if (bus.in_ready !== exp_r) begin
                miss++;
                $display("FAIL in_ready cycle %0d got %b required %b", cyc, bus.in_ready, exp_r);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bus.in_valid = 1'b0;
        bus.opcode   = '0;
        bus.tgt_id   = '0;
        bus.src0_id  = '0;
        bus.src1_id  = '0;
        bus.imm      = '0;
        for (int i = 0; i < N; i++) mr[i] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(1);
        issue(4'h1, 3, 0, 0, 8'h5A);
        issue(4'h3, 4, 3, 3, 8'h00);
        issue(4'h1, 1, 0, 0, 8'hFF);
        issue(4'h1, 2, 0, 0, 8'h01);
        issue(4'h2, 5, 1, 2, 8'h00);
        issue(4'h3, 6, 2, 1, 8'h00);
        issue(4'h1, 10, 0, 0, 8'h0F);
        issue(4'h6, 7, 10, 0, 8'h00);
        issue(4'h1, 11, 0, 0, 8'h81);
        issue(4'h1, 12, 0, 0, 8'h09);
        issue(4'h8, 8, 11, 2, 8'h00);
        issue(4'h9, 13, 11, 12, 8'h00);
        issue(4'hC, 3, 1, 2, 8'hAA);
        issue(4'h5, 14, 3, 3, 8'h00);
        issue(4'h0, 3, 1, 1, 8'h00);
        issue(4'h7, 15, 3, 1, 8'h00);
        idle(2);
        issue(4'h1, 0, 0, 0, 8'h0C);
        issue(4'h1, 15, 0, 0, 8'h0B);
        issue(4'hA, 9, 0, 15, 8'h00);
        issue(4'h5, 9, 9, 9, 8'h00);
        issue(4'h1, 0, 0, 0, 8'h10);
        issue(4'hA, 1, 0, 0, 8'h00);
        issue(4'h5, 1, 1, 1, 8'h00);
        idle(W + 2);
        issue(4'h1, 0, 0, 0, 8'h07);
        issue(4'h1, 1, 0, 0, 8'h05);
        issue(4'hA, 9, 0, 1, 8'h00);
        idle(2);
        do_reset();
        issue(4'h5, 4, 9, 9, 8'h00);
        issue(4'h2, 5, 0, 1, 8'h00);
        idle(2);
        for (int k = 0; k < 400; k++) begin
            issue(4'($urandom_range(0, 15)), int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
                  int'($urandom_range(0, N - 1)), W'($urandom));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(W + 4);
        vecs++;
        if (q.size() != 0) begin
            miss++;
            $display("FAIL pending_outputs got %0d outstanding required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
